// File: rtl/trigger_acq_ctrl_pkg.sv
// trigger_acq_ctrl_pkg: shared oscilloscope types and defaults
// State enum, decimation lookup, capture depth and auto timeout.
package trigger_acq_ctrl_pkg;

    localparam int DEPTH_DEF        = 512;
    localparam int AUTO_TIMEOUT_DEF = 2048;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_HOLD
    } acq_state_t;

    // Last decimator count for a time/div setting (factor N minus one).
    function automatic logic [5:0] dec_last(input logic [1:0] tpd);
        logic [5:0] r;
        unique case (tpd)
            2'b00:   r = 6'd0;
            2'b01:   r = 6'd3;
            2'b10:   r = 6'd15;
            default: r = 6'd63;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/trigger_acq_ctrl_trig_detect.sv
// trig_detect: threshold crossing comparator
// Rising: prev below level, sample at/above. Falling: mirror image.
module trig_detect (
    input  logic [7:0] prev_sample,
    input  logic [7:0] sample,
    input  logic [7:0] level,
    input  logic       slope,
    output logic       hit
);

    // Crossing test for the selected edge direction.
    always_comb begin
        hit = 1'b0;
        if (slope)
            hit = (prev_sample > level) && (sample <= level);
        else
            hit = (prev_sample < level) && (sample >= level);
    end

endmodule

// File: rtl/trigger_acq_ctrl.sv
// trigger_acq_ctrl: edge/auto trigger and frame capture controller
// Writes one decimated frame of DEPTH samples per trigger, then holds.
module trigger_acq_ctrl
    import trigger_acq_ctrl_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int AUTO_TIMEOUT = AUTO_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               sample,
    input  logic                     sample_valid,
    input  logic [7:0]               level,
    input  logic                     slope,
    input  logic                     mode,
    input  logic [1:0]               time_per_div,
    input  logic                     frame_ack,
    output logic                     wr_en,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data,
    output logic                     frame_ready,
    output logic                     triggered,
    output logic                     auto_fired
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(AUTO_TIMEOUT) + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(AUTO_TIMEOUT - 1);

    acq_state_t    state, state_nx;
    logic [5:0]    dec_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    prev_sample;
    logic [AW-1:0] cap_addr;
    logic          accept;
    logic          hit;
    logic          timeout;
    logic          do_wr;
    logic          wr_at0;
    logic          fire_trig;
    logic          fire_auto;

    assign accept      = sample_valid && (dec_cnt == 6'd0);
    assign timeout     = mode && (to_cnt == TO_LAST);
    assign frame_ready = (state == ST_HOLD);

    trig_detect u_trig_detect (
        .prev_sample (prev_sample),
        .sample      (sample),
        .level       (level),
        .slope       (slope),
        .hit         (hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_ARM;
        else
            state <= state_nx;
    end

    // Next state and write/pulse decisions for the current sample.
    always_comb begin
        state_nx  = state;
        do_wr     = 1'b0;
        wr_at0    = 1'b0;
        fire_trig = 1'b0;
        fire_auto = 1'b0;
        unique case (state)
            ST_ARM: begin
                if (accept)
                    state_nx = ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
                if (accept && hit) begin
                    do_wr     = 1'b1;
                    wr_at0    = 1'b1;
                    fire_trig = 1'b1;
                    state_nx  = ST_CAPTURE;
                end else if (accept && timeout) begin
                    do_wr     = 1'b1;
                    wr_at0    = 1'b1;
                    fire_auto = 1'b1;
                    state_nx  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (accept) begin
                    do_wr = 1'b1;
                    if (cap_addr == LAST_ADDR)
                        state_nx = ST_HOLD;
                end
            end
            default: begin
                if (frame_ack)
                    state_nx = ST_ARM;
            end
        endcase
    end

    // Registered write port, pulses and capture address.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'd0;
            triggered  <= 1'b0;
            auto_fired <= 1'b0;
            cap_addr   <= '0;
        end else begin
            wr_en      <= do_wr;
            triggered  <= fire_trig;
            auto_fired <= fire_auto;
            if (do_wr) begin
                wr_addr  <= wr_at0 ? '0 : cap_addr;
                wr_data  <= sample;
                cap_addr <= wr_at0 ? AW'(1) : cap_addr + AW'(1);
            end
        end
    end

    // Decimator, previous-sample and auto timeout tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt     <= 6'd0;
            to_cnt      <= '0;
            prev_sample <= 8'd0;
        end else begin
            if (state == ST_HOLD && frame_ack)
                dec_cnt <= 6'd0;
            else if (sample_valid)
                dec_cnt <= (dec_cnt >= dec_last(time_per_div)) ?
                           6'd0 : dec_cnt + 6'd1;
            if (accept && (state == ST_ARM || state == ST_WAIT_TRIG))
                prev_sample <= sample;
            if (state != ST_WAIT_TRIG || !mode)
                to_cnt <= '0;
            else if (accept)
                to_cnt <= to_cnt + TW'(1);
        end
    end

endmodule

// File: doc/trigger_acq_ctrl.md
TRIGGER_ACQ_CTRL -- requirements
Module: trigger_acq_ctrl

Interface
REQ-001 Parameter DEPTH, 512: capture buffer depth in samples, power of two.
REQ-002 Parameter AUTO_TIMEOUT, 2048: decimated samples waited in auto mode before a forced trigger.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 sample  in  8  unsigned ADC sample.
REQ-006 sample_valid  in  1  qualifies sample for one clk cycle.
REQ-007 level  in  8  trigger threshold, unsigned.
REQ-008 slope  in  1  0 = rising edge, 1 = falling edge.
REQ-009 mode  in  1  0 = normal (wait forever), 1 = auto (timeout trigger).
REQ-010 time_per_div  in  2  decimation select: 00->1, 01->4, 10->16, 11->64.
REQ-011 frame_ack  in  1  display pulse: frame consumed, rearm allowed.
REQ-012 wr_en  out  1  buffer write strobe.
REQ-013 wr_addr  out  log2(DEPTH)  buffer write address.
REQ-014 wr_data  out  8  buffer write data.
REQ-015 frame_ready  out  1  level, high while a complete frame is held.
REQ-016 triggered  out  1  one-cycle pulse on trigger; auto_fired  out  1  one-cycle pulse on forced trigger.

Function
REQ-017 States: ARM, WAIT_TRIG, CAPTURE, HOLD; one-hot or binary is free.
REQ-018 Decimator: a counter over sample_valid cycles accepts one sample per factor N; it restarts on entering ARM; with N=1 every valid sample is accepted.
REQ-019 ARM: the first accepted sample loads prev_sample only; next state is WAIT_TRIG.
REQ-020 Rising trigger: prev_sample < level and sample >= level on an accepted sample.
REQ-021 Falling trigger: prev_sample > level and sample <= level on an accepted sample.
REQ-022 prev_sample updates on every accepted sample in WAIT_TRIG.
REQ-023 On a trigger, that same sample is written at address 0; triggered pulses in the same cycle as wr_en; the next state is CAPTURE.
REQ-024 Auto mode: a timeout counter counts accepted samples in WAIT_TRIG.
REQ-025 Auto timeout: when the timeout counter reaches AUTO_TIMEOUT-1 without a trigger, that sample is written at address 0, auto_fired pulses and the next state is CAPTURE.
REQ-026 A real trigger and the timeout on the same sample: the real trigger wins; triggered=1, auto_fired=0.
REQ-027 In normal mode the timeout counter is held at 0.
REQ-028 CAPTURE: every accepted sample asserts wr_en for exactly one cycle, with wr_data = sample, and increments wr_addr.
REQ-029 After the write at DEPTH-1 the state moves to HOLD; wr_addr shall not wrap into a new frame.
REQ-030 HOLD: frame_ready=1 and no writes.
REQ-031 On frame_ack in HOLD: frame_ready drops next cycle and the state moves to ARM.
REQ-032 frame_ack outside HOLD is ignored.
REQ-033 wr_en, wr_addr and wr_data are registered, so a write appears one cycle after the accepted sample_valid.
REQ-034 slope, level, mode and time_per_div are sampled live; a change takes effect on the next accepted sample with no restart.

Reset
REQ-035 rst forces state ARM, with wr_en=0, wr_addr=0, wr_data=0, frame_ready=0, triggered=0, auto_fired=0, and the decimation, timeout and prev_sample registers at 0.
REQ-036 rst asserted mid-CAPTURE or in HOLD discards the partial or held frame; no further writes occur until a new trigger.

Structure
REQ-037 A shared oscilloscope package holds the state enum, the decimation lookup (time_per_div to N) and the DEPTH/AUTO_TIMEOUT defaults.
REQ-038 One sub-module, trig_detect (combinational comparator: prev_sample, sample, level, slope -> hit), shall be instantiated.

Verification
REQ-039 Ramp test: normal mode, level=128, slope=0, N=1, ramp 0..255 -> triggered with wr_data=128 at wr_addr=0; frame_ready after 512 writes.
REQ-040 Falling-edge test: slope=1, level=100, samples 120,110,100 -> trigger on 100; no trigger on a rising ramp.
REQ-041 Auto timeout test: mode=1, constant sample=50, level=200 -> auto_fired after 2048 accepted samples, then a full frame.
REQ-042 Decimation test: time_per_div=10, continuous valid -> wr_en spacing of 16 sample_valid cycles; 512 writes in total.
REQ-043 Handshake and reset test: frame_ack in HOLD returns the block to ARM and the next frame captures; rst at address 300 leaves all outputs 0 with no writes until a retrigger.
